imem_loader: RTL and testbench

//  Write-side companion to the byte-addressed little-endian instruction memory.
//  - Receives a program image as a byte stream over a valid/ready handshake.
//  - Writes the image byte-by-byte into the memory write port, starting at address 0.
//  - Holds the CPU in reset while loading, then releases it.
//  - Sits between the host/UART byte source, the instruction memory write port and the core reset.

---
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 tb/tb_imem_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader for the instruction memory
//
// Takes a program image over a valid/ready byte stream (LEN_lo, LEN_hi, LEN
// payload bytes, optional checksum byte). It writes the payload bytes to the
// instruction memory write port starting at address 0, and holds the core in
// reset while the load is in progress.
//
// Optional feature macro: CHECKSUM_EN. When defined, a trailing XOR checksum
// byte is expected after the payload and is checked in a CHK state.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high
//   start       in   1-cycle pulse, opens a load session (ignored unless idle)
//   rx_data     in   stream byte
//   rx_valid    in   rx_data is valid
//   rx_ready    out  loader accepts a byte this cycle (combinational from state)
//   imem_we     out  registered memory byte write enable
//   imem_addr   out  registered memory byte address
//   imem_wdata  out  registered memory write byte
//   cpu_hold    out  hold the core in reset (registered busy | error)
//   busy        out  session in progress
//   done        out  sticky: last session completed OK
//   error       out  sticky: last session failed
module imem_loader #(
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_LOAD,
`ifdef CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  // Where the FSM goes once the payload has been fully received.
`ifdef CHECKSUM_EN
  localparam state_t S_AFTER_PAYLOAD = S_CHK;
`else
  localparam state_t S_AFTER_PAYLOAD = S_DONE;
`endif

  localparam logic [16:0] DEPTH_LIM = 17'(IMEM_DEPTH);

  state_t      state;
  state_t      state_next;
  logic [15:0] len;
  logic [15:0] count;
  logic        accept;
  logic [15:0] hdr_len;
  logic        last_byte;
`ifdef CHECKSUM_EN
  logic [7:0]  csum;
`endif

  function automatic logic is_active(input state_t s);
    return (s == S_HDR0) || (s == S_HDR1) || (s == S_LOAD)
`ifdef CHECKSUM_EN
      || (s == S_CHK)
`endif
      ;
  endfunction

  assign accept    = rx_valid && rx_ready;
  // Full length as it will look once the high byte is latched in HDR1.
  assign hdr_len   = {rx_data, len[7:0]};
  assign last_byte = (count == len - 16'd1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_HDR0;
      S_HDR0: if (accept) state_next = S_HDR1;
      S_HDR1: begin
        if (accept) begin
          // Length is checked before any write, so the address never wraps.
          if ({1'b0, hdr_len} > DEPTH_LIM) begin
            state_next = S_ERR;
          end else if (hdr_len == 16'd0) begin
            state_next = S_AFTER_PAYLOAD;
          end else begin
            state_next = S_LOAD;
          end
        end
      end
      S_LOAD: if (accept && last_byte) state_next = S_AFTER_PAYLOAD;
`ifdef CHECKSUM_EN
      S_CHK: if (accept) state_next = (rx_data == csum) ? S_DONE : S_ERR;
`endif
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy     = is_active(state);
    rx_ready = is_active(state);
  end

  // Datapath: length, counter, checksum, write port and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      len        <= '0;
      count      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b0;
`ifdef CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      imem_we <= 1'b0;

      if (state == S_IDLE && start) begin
        count <= '0;
        done  <= 1'b0;
        error <= 1'b0;
`ifdef CHECKSUM_EN
        csum  <= '0;
`endif
      end

      if (state == S_HDR0 && accept) len[7:0]  <= rx_data;
      if (state == S_HDR1 && accept) len[15:8] <= rx_data;

      if (state == S_LOAD && accept) begin
        imem_we    <= 1'b1;
        imem_addr  <= count[ADDR_W-1:0];
        imem_wdata <= rx_data;
        count      <= count + 16'd1;
`ifdef CHECKSUM_EN
        csum       <= csum ^ rx_data;
`endif
      end

      if (state_next == S_DONE) done  <= 1'b1;
      if (state_next == S_ERR)  error <= 1'b1;

      // A start that clears error always enters an active state, so the
      // hold stays asserted across the error-to-new-session transition.
      cpu_hold <= is_active(state_next) || (state_next == S_ERR) || error;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [7:0]    imem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;

  int tests = 0;
  int fails = 0;
  bit tog   = 1'b0;

  logic [31:0] wr_q[$];

  imem_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Every write the DUT makes, as {addr, data}.
  always @(negedge clk) begin
    if (imem_we) wr_q.push_back(32'({imem_addr, imem_wdata}));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: always valid, 1: valid toggles every cycle, 2: random gaps
  task automatic send_byte(input logic [7:0] b, input int mode, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      rx_data = b;
      case (mode)
        0: rx_valid = 1'b1;
        1: begin tog = ~tog; rx_valid = tog; end
        default: rx_valid = 1'($urandom_range(0, 1));
      endcase
      if (rx_valid && rx_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic bq_t make_stream(input int len);
    bq_t s;
    s.push_back(8'(len));
    s.push_back(8'(len >> 8));
    if (len <= DEPTH) begin
      for (int i = 0; i < len; i++) s.push_back(8'($urandom));
    end
    return s;
  endfunction

`ifdef CHECKSUM_EN
  function automatic bq_t with_chk(input bq_t s, input bit bad);
    bq_t r;
    logic [7:0] x;
    r = s;
    x = 8'h00;
    for (int i = 2; i < s.size(); i++) x ^= s[i];
    r.push_back(bad ? ~x : x);
    return r;
  endfunction
`endif

  // Reference: decode the stream from the format rules, drive it, and compare
  // the resulting writes and flags.
  task automatic run_session(input string tag, input bq_t s, input int mode);
    int          len;
    int          nsend;
    int          miss;
    int          wait_n;
    bit          exp_err;
    bit          ok;
    logic [7:0]  x;
    logic [31:0] exp_q[$];

    len     = int'(s[0]) | (int'(s[1]) << 8);
    x       = 8'h00;
    exp_err = 1'b0;
    exp_q   = {};
    if (len > DEPTH) begin
      exp_err = 1'b1;
      nsend   = 2;
    end else begin
      for (int i = 0; i < len; i++) begin
        exp_q.push_back(32'({10'(i), s[2 + i]}));
        x ^= s[2 + i];
      end
      nsend = 2 + len;
`ifdef CHECKSUM_EN
      nsend   = nsend + 1;
      exp_err = (s[2 + len] != x);
`endif
    end

    @(negedge clk);
    wr_q  = {};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, " hold_after_start"}, 32'(cpu_hold), 32'd1);
    chk({tag, " flags_cleared"}, 32'({done, error}), 32'd0);

    miss = 0;
    for (int i = 0; i < nsend; i++) begin
      send_byte(s[i], mode, ok);
      if (!ok) miss++;
    end
    chk({tag, " bytes_accepted"}, 32'(miss), 32'd0);

    @(negedge clk);
    rx_valid = 1'b0;
    wait_n = 0;
    while (busy && wait_n < 8) begin
      @(negedge clk);
      wait_n++;
    end
    chk({tag, " busy_end"}, 32'(busy), 32'd0);
    chk({tag, " ready_end"}, 32'(rx_ready), 32'd0);
    chk({tag, " done"}, 32'(done), 32'(!exp_err));
    chk({tag, " error"}, 32'(error), 32'(exp_err));
    chk({tag, " cpu_hold"}, 32'(cpu_hold), 32'(exp_err));

    // Bytes offered while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
    end
    chk({tag, " idle_ready"}, 32'(rx_ready), 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    chk({tag, " sticky_flags"}, 32'({done, error}), 32'({!exp_err, exp_err}));

    chk({tag, " nwrites"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      chk({tag, " write"}, wr_q[i], exp_q[i]);
    end
  endtask

  initial begin
    bq_t s;
    bit  ok;
    int  len;

    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        32'({rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error}), 32'd0);
    reset = 1'b0;

    // Basic 4-byte image, no gaps.
    s = '{8'h04, 8'h00, 8'hB3, 8'h00, 8'h31, 8'h00};
`ifdef CHECKSUM_EN
    s = with_chk(s, 1'b0);
`endif
    run_session("t1_basic", s, 0);

    // Same image with valid toggling every cycle.
    run_session("t2_gaps", s, 1);

    // Zero-length image.
    s = '{8'h00, 8'h00};
`ifdef CHECKSUM_EN
    s = with_chk(s, 1'b0);
`endif
    run_session("t3_zero", s, 0);

    // Length just over the memory size.
    s = '{8'h01, 8'h04};
    run_session("t4_toolong", s, 0);

    // Abandon a session by reset after 3 of 8 payload bytes.
    s = '{8'h08, 8'h00, 8'h5A, 8'hC3, 8'h7E};
    @(negedge clk);
    wr_q  = {};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(s[i], 0, ok);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_reset_outputs",
        32'({rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error}), 32'd0);
    rx_valid = 1'b1;
    repeat (5) @(negedge clk);
    rx_valid = 1'b0;
    chk("t5_nwrites", 32'(wr_q.size()), 32'd3);
    chk("t5_w0", wr_q[0], 32'({10'd0, 8'h5A}));
    chk("t5_w2", wr_q[2], 32'({10'd2, 8'h7E}));

    s = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef CHECKSUM_EN
    s = with_chk(s, 1'b0);
`endif
    run_session("t5_fresh", s, 2);

`ifdef CHECKSUM_EN
    s = '{8'h02, 8'h00, 8'hAA, 8'h55, 8'hFF};
    run_session("t6_chk_ok", s, 0);
    s = '{8'h02, 8'h00, 8'hAA, 8'h55, 8'h00};
    run_session("t6_chk_bad", s, 0);
`endif

    // Boundaries: single byte and a full memory image.
    s = make_stream(1);
`ifdef CHECKSUM_EN
    s = with_chk(s, 1'b0);
`endif
    run_session("b_len1", s, 0);
    s = make_stream(DEPTH);
`ifdef CHECKSUM_EN
    s = with_chk(s, 1'b0);
`endif
    run_session("b_full", s, 0);

    // Randomized sessions.
    for (int k = 0; k < 12; k++) begin
      len = (k == 5) ? DEPTH + 1 + int'($urandom_range(0, 100)) : int'($urandom_range(0, 48));
      s = make_stream(len);
`ifdef CHECKSUM_EN
      if (len <= DEPTH) s = with_chk(s, 1'($urandom_range(0, 3) == 0));
`endif
      run_session("rand", s, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
